// File: rtl/mem_arbiter.sv
// ============================================================================
// Module   : mem_arbiter
// Brief    : Two-port (CPU/debug) arbiter for one shared single-port data RAM.
//            The optional debug starvation guard is enabled by ARB_STARVE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter #(
    parameter int WIDTH        = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [WIDTH-1:0] cpu_addr,
    input  logic [WIDTH-1:0] cpu_wd,
    output logic             cpu_gnt,
    output logic             cpu_stall,
    output logic             cpu_rvalid,
    output logic [WIDTH-1:0] cpu_rdata,
    input  logic             dbg_req,
    input  logic             dbg_we,
    input  logic [WIDTH-1:0] dbg_addr,
    input  logic [WIDTH-1:0] dbg_wd,
    output logic             dbg_gnt,
    output logic             dbg_rvalid,
    output logic [WIDTH-1:0] dbg_rdata,
    output logic             ram_we,
    output logic [WIDTH-1:0] ram_addr,
    output logic [WIDTH-1:0] ram_wd,
    input  logic [WIDTH-1:0] ram_rdata
);

    typedef enum logic [1:0] {
        PEND_NONE = 2'd0,
        PEND_CPU  = 2'd1,
        PEND_DBG  = 2'd2
    } pend_t;

    pend_t pend_q, pend_d;
    logic  w_dbg_force;

    if (STARVE_LIMIT < 1) begin : g_bad_limit
        $error("mem_arbiter: STARVE_LIMIT must be at least 1");
    end

`ifdef ARB_STARVE_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0] starve_cnt_q, starve_cnt_d;

    assign w_dbg_force = dbg_req && (starve_cnt_q == CW'(STARVE_LIMIT));

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!dbg_req || dbg_gnt) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != CW'(STARVE_LIMIT)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    assign w_dbg_force = 1'b0;
`endif

    // Grants are gated by reset so nothing reaches the RAM while reset is held.
    always_comb begin
        cpu_gnt = 1'b0;
        dbg_gnt = 1'b0;
        if (!reset) begin
            if (dbg_req && (w_dbg_force || !cpu_req)) begin
                dbg_gnt = 1'b1;
            end else if (cpu_req) begin
                cpu_gnt = 1'b1;
            end
        end
    end

    assign cpu_stall = cpu_req && !cpu_gnt && !reset;

    always_comb begin
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_wd   = '0;
        if (cpu_gnt) begin
            ram_we   = cpu_we;
            ram_addr = cpu_addr;
            ram_wd   = cpu_wd;
        end else if (dbg_gnt) begin
            ram_we   = dbg_we;
            ram_addr = dbg_addr;
            ram_wd   = dbg_wd;
        end
    end

    // Remembers who owns the read data the RAM returns next cycle.
    always_comb begin
        pend_d = PEND_NONE;
        if (cpu_gnt && !cpu_we) begin
            pend_d = PEND_CPU;
        end else if (dbg_gnt && !dbg_we) begin
            pend_d = PEND_DBG;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q <= PEND_NONE;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign cpu_rvalid = (pend_q == PEND_CPU);
    assign dbg_rvalid = (pend_q == PEND_DBG);
    assign cpu_rdata  = ram_rdata;
    assign dbg_rdata  = ram_rdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Directed scoreboard bench for mem_arbiter with a one-cycle RAM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wd = '0;
    logic        cpu_gnt, cpu_stall, cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        dbg_req = 1'b0, dbg_we = 1'b0;
    logic [31:0] dbg_addr = '0, dbg_wd = '0;
    logic        dbg_gnt, dbg_rvalid;
    logic [31:0] dbg_rdata;
    logic        ram_we;
    logic [31:0] ram_addr, ram_wd;
    logic [31:0] ram_rdata = '0;

    logic [31:0] mem [256];
    logic [31:0] cpu_exp_q [$];
    logic [31:0] dbg_exp_q [$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic        exp_dbg;

    mem_arbiter #(.WIDTH(32), .STARVE_LIMIT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wd     (cpu_wd),
        .cpu_gnt    (cpu_gnt),
        .cpu_stall  (cpu_stall),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .dbg_req    (dbg_req),
        .dbg_we     (dbg_we),
        .dbg_addr   (dbg_addr),
        .dbg_wd     (dbg_wd),
        .dbg_gnt    (dbg_gnt),
        .dbg_rvalid (dbg_rvalid),
        .dbg_rdata  (dbg_rdata),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wd     (ram_wd),
        .ram_rdata  (ram_rdata)
    );

    always #5 clk = ~clk;

    // Single-port RAM model: read data appears one cycle after the address.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr[7:0]] <= ram_wd;
        ram_rdata <= mem[ram_addr[7:0]];
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                         input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd);
        @(posedge clk);
        #1;
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wd = cd;
        dbg_req = dr; dbg_we = dw; dbg_addr = da; dbg_wd = dd;
        #3;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cpu_gnt"},    {31'b0, cpu_gnt},    32'h0);
        check({tag, "_dbg_gnt"},    {31'b0, dbg_gnt},    32'h0);
        check({tag, "_cpu_stall"},  {31'b0, cpu_stall},  32'h0);
        check({tag, "_cpu_rvalid"}, {31'b0, cpu_rvalid}, 32'h0);
        check({tag, "_dbg_rvalid"}, {31'b0, dbg_rvalid}, 32'h0);
        check({tag, "_ram_we"},     {31'b0, ram_we},     32'h0);
        check({tag, "_ram_addr"},   ram_addr,            32'h0);
        check({tag, "_ram_wd"},     ram_wd,              32'h0);
    endtask

    // Monitor: every rvalid must match the oldest expected read of that port.
    always @(negedge clk) begin
        if (cpu_rvalid) begin
            if (cpu_exp_q.size() == 0) check("cpu_rvalid_unexpected", {31'b0, cpu_rvalid}, 32'h0);
            else                       check("cpu_rdata", cpu_rdata, cpu_exp_q.pop_front());
        end
        if (dbg_rvalid) begin
            if (dbg_exp_q.size() == 0) check("dbg_rvalid_unexpected", {31'b0, dbg_rvalid}, 32'h0);
            else                       check("dbg_rdata", dbg_rdata, dbg_exp_q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hDEAD0000 | i;

        // Outputs stay quiet in reset even with write requests pending.
        drive(1'b1, 1'b1, 32'h10, 32'hAA, 1'b1, 1'b1, 32'h20, 32'h55);
        check_all_zero("rst");
        drive(1'b1, 1'b1, 32'h10, 32'hAA, 1'b1, 1'b0, 32'h20, 32'h0);
        check_all_zero("rst2");

        // Simultaneous requests: cpu write wins, granted in first cycle after reset.
        @(posedge clk);
        #1 reset = 1'b0;
        #3;
        check("sim_cpu_gnt",   {31'b0, cpu_gnt},   32'h1);
        check("sim_dbg_gnt",   {31'b0, dbg_gnt},   32'h0);
        check("sim_ram_we",    {31'b0, ram_we},    32'h1);
        check("sim_ram_addr",  ram_addr,           32'h10);
        check("sim_ram_wd",    ram_wd,             32'hAA);
        check("sim_cpu_stall", {31'b0, cpu_stall}, 32'h0);

        // Debug alone is granted, readback arrives one cycle later.
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0);
        check("dbg_gnt",      {31'b0, dbg_gnt}, 32'h1);
        check("dbg_cpu_gnt",  {31'b0, cpu_gnt}, 32'h0);
        check("dbg_ram_addr", ram_addr,         32'h20);
        check("dbg_ram_we",   {31'b0, ram_we},  32'h0);
        dbg_exp_q.push_back(32'hDEAD0020);
        idle();
        check("dbg_rvalid",     {31'b0, dbg_rvalid}, 32'h1);
        check("dbg_cpu_rvalid", {31'b0, cpu_rvalid}, 32'h0);
        check("idle_ram_addr",  ram_addr,            32'h0);

        // Write then read the same address.
        drive(1'b1, 1'b1, 32'h04, 32'h1234, 1'b0, 1'b0, 32'h0, 32'h0);
        check("wr_cpu_gnt", {31'b0, cpu_gnt}, 32'h1);
        drive(1'b1, 1'b0, 32'h04, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("rd_cpu_gnt", {31'b0, cpu_gnt},    32'h1);
        check("wr_no_rvalid", {31'b0, cpu_rvalid}, 32'h0);
        cpu_exp_q.push_back(32'h1234);
        idle();
        check("wr_rd_rvalid", {31'b0, cpu_rvalid}, 32'h1);

        // Back-to-back grants alternating ports.
        drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("b2b_cpu_gnt0", {31'b0, cpu_gnt}, 32'h1);
        cpu_exp_q.push_back(32'hAA);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h04, 32'h0);
        check("b2b_dbg_gnt",    {31'b0, dbg_gnt},    32'h1);
        check("b2b_cpu_rvalid0", {31'b0, cpu_rvalid}, 32'h1);
        dbg_exp_q.push_back(32'h1234);
        drive(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("b2b_cpu_gnt1",   {31'b0, cpu_gnt},    32'h1);
        check("b2b_dbg_rvalid", {31'b0, dbg_rvalid}, 32'h1);
        cpu_exp_q.push_back(32'hDEAD0020);
        idle();
        check("b2b_cpu_rvalid1", {31'b0, cpu_rvalid}, 32'h1);
        idle();
        check("idle_cpu_rvalid", {31'b0, cpu_rvalid}, 32'h0);

        // Both ports hold write requests for 20 cycles.
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b1, 32'h40, 32'h11, 1'b1, 1'b1, 32'h44, 32'h22);
`ifdef ARB_STARVE_EN
            exp_dbg = ((i % 5) == 4);
`else
            exp_dbg = 1'b0;
`endif
            check($sformatf("stv_dbg_gnt_%0d", i),   {31'b0, dbg_gnt},   {31'b0, exp_dbg});
            check($sformatf("stv_cpu_gnt_%0d", i),   {31'b0, cpu_gnt},   {31'b0, ~exp_dbg});
            check($sformatf("stv_cpu_stall_%0d", i), {31'b0, cpu_stall}, {31'b0, exp_dbg});
            check($sformatf("stv_ram_addr_%0d", i),  ram_addr,           exp_dbg ? 32'h44 : 32'h40);
        end
        idle();

        // Reset asserted while a cpu read is in flight.
        drive(1'b1, 1'b0, 32'h08, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("mid_cpu_gnt", {31'b0, cpu_gnt}, 32'h1);
        reset = 1'b1;
        #1;
        check_all_zero("mid_rst_now");
        drive(1'b1, 1'b0, 32'h08, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        check_all_zero("mid_rst1");
        drive(1'b1, 1'b0, 32'h08, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        check_all_zero("mid_rst2");
        @(posedge clk);
        #1 reset = 1'b0;
        #3;
        check("post_rst_cpu_gnt",    {31'b0, cpu_gnt},    32'h1);
        check("post_rst_cpu_rvalid", {31'b0, cpu_rvalid}, 32'h0);
        cpu_exp_q.push_back(32'hDEAD0008);
        idle();
        check("post_rst_rd_rvalid", {31'b0, cpu_rvalid}, 32'h1);
        idle();
        idle();

        check("cpu_queue_drained", cpu_exp_q.size(), 32'h0);
        check("dbg_queue_drained", dbg_exp_q.size(), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the data and address width in bits.
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, the number of consecutive denied debug-request cycles before the debug port is forced to win.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have ports cpu_req, cpu_we, input, 1 bit each: data-stage access request and write enable.
REQ-006 SHALL have ports cpu_addr, cpu_wd, input, WIDTH bits each: data-stage address and write data.
REQ-007 SHALL have ports cpu_gnt, cpu_stall, cpu_rvalid, output, 1 bit each.
REQ-008 SHALL have port cpu_rdata, output, WIDTH bits.
REQ-009 SHALL have ports dbg_req, dbg_we, input, 1 bit each: debug/loader access request and write enable.
REQ-010 SHALL have ports dbg_addr, dbg_wd, input, WIDTH bits each.
REQ-011 SHALL have ports dbg_gnt, dbg_rvalid, output, 1 bit each.
REQ-012 SHALL have port dbg_rdata, output, WIDTH bits.
REQ-013 SHALL have ports ram_we, output, 1 bit; ram_addr and ram_wd, output, WIDTH bits each; ram_rdata, input, WIDTH bits.
REQ-014 SHALL drive ram_addr to both the read and write address of the shared single-port data RAM.

Function
REQ-015 SHALL issue at most one RAM access per cycle; cpu_gnt and dbg_gnt are never both 1.
REQ-016 SHALL assert the grant combinationally in the same cycle as the winning request; a grant means the access is issued that cycle.
REQ-017 Each requester SHALL hold req, we, addr and wd stable until it sees its grant; the arbiter does not register request fields.
REQ-018 Default priority: cpu_req wins over dbg_req; dbg wins when it is the only requester.
REQ-019 SHALL drive ram_addr, ram_wd and ram_we from the granted port; ram_we = granted port's we; with no grant, ram_we=0 and ram_addr/ram_wd=0.
REQ-020 cpu_stall SHALL equal cpu_req & ~cpu_gnt.
REQ-021 The RAM returns read data one cycle after the address; SHALL hold a pending-read register with states NONE, CPU and DBG.
REQ-022 Pending-read register: next state = CPU on a granted CPU read, DBG on a granted DBG read, otherwise NONE.
REQ-023 cpu_rvalid SHALL be 1 exactly when the register is CPU, and dbg_rvalid exactly when it is DBG; each lasts one cycle per read.
REQ-024 cpu_rdata and dbg_rdata SHALL both carry ram_rdata unmodified; the rvalid flags qualify them.
REQ-025 Writes SHALL produce no rvalid.
REQ-026 Back-to-back grants to either port on consecutive cycles SHALL be supported with full throughput.

Reset
REQ-027 While reset=1: grants, stall, both rvalid outputs, ram_we, ram_addr and ram_wd are 0; the pending register is NONE; the starvation counter is 0.
REQ-028 A read granted in the cycle reset asserts SHALL produce no rvalid after reset releases.
REQ-029 The first grant SHALL be possible in the first clock cycle after reset deasserts.

Configuration
REQ-030 Macro ARB_STARVE_EN SHALL enable the starvation guard.
REQ-031 With ARB_STARVE_EN: starve_cnt increments each cycle in which dbg_req=1 and dbg_gnt=0.
REQ-032 With ARB_STARVE_EN: starve_cnt saturates at STARVE_LIMIT and clears when dbg_gnt=1 or dbg_req=0.
REQ-033 With ARB_STARVE_EN: when starve_cnt==STARVE_LIMIT and dbg_req=1, dbg wins over cpu for one cycle and cpu_stall asserts.
REQ-034 Without ARB_STARVE_EN: strict CPU priority applies; the counter is not built, and dbg can starve indefinitely.

Verification
REQ-035 Simultaneous requests: cpu write addr 0x10 data 0xAA and dbg read addr 0x20 in the same cycle -> cpu_gnt=1, ram_we=1, ram_addr=0x10; dbg_gnt=0 that cycle.
REQ-036 Debug readback: in the next cycle dbg alone is granted -> one cycle later dbg_rvalid=1, dbg_rdata equals RAM[0x20], and cpu_rvalid=0.
REQ-037 Starvation, ARB_STARVE_EN defined, STARVE_LIMIT=4: cpu_req and dbg_req held at 1 -> cpu granted in cycles 0-3, dbg granted in cycle 4 with cpu_stall=1, cpu granted in cycle 5.
REQ-038 Same stimulus without ARB_STARVE_EN -> dbg_gnt stays 0 for 20 cycles and cpu_stall stays 0.
REQ-039 Reset mid-read: cpu read of 0x08 granted, reset asserted before the next edge -> cpu_rvalid stays 0, and all outputs are 0 while reset=1.
REQ-040 Write-then-read: cpu write 0x04 data 0x1234, then cpu read 0x04 on the next cycle -> cpu_rvalid=1 with cpu_rdata=0x1234 two cycles after the write grant.
